braid_mix_scheduler: RTL and testbench
======================================

BRAID_MIX_SCHEDULER -- requirements
Module: braid_mix_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter LANES, default 4, SHALL set the number of braid input lanes.
REQ-003 Parameter STAGES, default 32, SHALL set the number of mixer stages sequenced per run.
REQ-004 Parameter MIX_CYCLES, default 16, SHALL set the clock cycles each stage's mixers run; legal range 1..65535.
REQ-005 Port list SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  run request, sampled in IDLE only
- abort  in  1  synchronous run cancel
- load_req  in  LANES  per-lane fluid-ready request, held until granted
- load_gnt  out  LANES  one-hot load-valve grant, one-cycle pulse
- mix_en  out  1  mixer actuation for current stage
- step  out  1  one-cycle stage-advance pulse
- stage_idx  out  $clog2(STAGES)  current stage
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle run-complete pulse

Function
REQ-006 FSM states SHALL be IDLE, LOAD, MIX, ADVANCE, DONE.
REQ-007 IDLE->LOAD SHALL occur on the cycle after start=1; start outside IDLE SHALL be ignored.
REQ-008 On entering LOAD, the loaded mask SHALL clear, and stage_idx SHALL be 0.
REQ-009 In LOAD, each cycle the round-robin arbiter SHALL pick one requesting, not-yet-loaded lane. load_gnt SHALL be registered: the pick appears on the next cycle. The lane is then marked loaded.
REQ-010 The round-robin pointer SHALL start at lane 0 after reset. After each grant it SHALL move to the lane following the granted lane. It SHALL persist across runs.
REQ-011 Each lane SHALL be granted exactly once per run. load_req from loaded lanes SHALL be ignored.
REQ-012 LOAD->MIX SHALL occur on the cycle after the loaded mask becomes all-ones.
REQ-013 In MIX, mix_en SHALL be 1 for exactly MIX_CYCLES consecutive cycles. The state SHALL then go to ADVANCE.
REQ-014 ADVANCE SHALL last one cycle with step=1 and mix_en=0.
REQ-015 In ADVANCE, if stage_idx<STAGES-1, stage_idx SHALL increment and the state SHALL go to MIX. Otherwise the state SHALL go to DONE.
REQ-016 DONE SHALL last one cycle with done=1. It SHALL then return to IDLE with stage_idx=0.
REQ-017 abort=1 in any state SHALL force IDLE on the next cycle. In that cycle mix_en, step, load_gnt and done SHALL be 0, and the loaded mask SHALL be cleared.
REQ-018 abort SHALL have priority over start and over all other transitions.
REQ-019 The mix counter SHALL be 16 bits and SHALL reload on every MIX entry. It SHALL never wrap within a stage.

Reset
REQ-020 While rst_n=0, the block SHALL be in IDLE, and all outputs, the loaded mask, the mix counter and the RR pointer SHALL be 0.
REQ-021 Reset mid-run SHALL discard all progress with no done pulse.

Configuration
REQ-022 When BRAID_SCHED_PERF_EN is defined, the block SHALL add output run_cycles[15:0]. It SHALL clear on IDLE->LOAD, increment each busy cycle, saturate at 16'hFFFF, hold after DONE or abort, and reset to 0.
REQ-023 Without BRAID_SCHED_PERF_EN, the port and its counter SHALL be absent.

Structure
REQ-024 Package braid_sched_pkg SHALL hold the state enum, default-parameter constants and the 16-bit counter width constant.
REQ-025 The round-robin grant logic SHALL be sub-module braid_rr_arbiter (req, mask and pointer in; one-hot grant out).

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- load_req=4'b1111 held, start pulse -> load_gnt 0001,0010,0100,1000 on consecutive cycles, then MIX.
- MIX_CYCLES=4, STAGES=32 -> mix_en high 4 cycles per stage, 32 step pulses, stage_idx 0..31, one done pulse, busy low after.
- Run 1 ends with last grant at lane 1; run 2 with load_req=4'b1111 -> first grant lane 2.
- load_req=4'b0101 only -> grants 0001,0100; state stays LOAD; raise lanes 1 and 3 -> grants 0010,1000, then MIX.
- abort during MIX at stage 7 -> next cycle IDLE, mix_en=0, stage_idx=0, no done; a new start runs normally.
- rst_n low mid-LOAD -> all outputs 0 immediately; with BRAID_SCHED_PERF_EN, run_cycles=0.

Source files
------------

// File: rtl/braid_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | braid_sched_pkg                                                            |
// | Shared state encoding and defaults for the braid mix scheduler.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package braid_sched_pkg;

  localparam int DEF_LANES      = 4;
  localparam int DEF_STAGES     = 32;
  localparam int DEF_MIX_CYCLES = 16;
  localparam int CNT_W          = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_MIX     = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/braid_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | braid_rr_arbiter                                                           |
// | Round-robin pick of one requesting, not-yet-loaded lane, starting at ptr.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module braid_rr_arbiter
  import braid_sched_pkg::*;
#(
  parameter int  LANES = DEF_LANES,
  localparam int PW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] req,
  input  logic [LANES-1:0] mask,
  input  logic [PW-1:0]    ptr,
  output logic [LANES-1:0] grant
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan lanes in the order ptr, ptr+1, ... wrapping at LANES.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(LANES)) sum = sum - (PW+1)'(LANES);
      idx = sum[PW-1:0];
      if (!found && req[idx] && !mask[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/braid_mix_scheduler.sv
// +----------------------------------------------------------------------------+
// | braid_mix_scheduler                                                        |
// | Loads every braid lane once, then sequences STAGES mixer stages.           |
// | Optional run-cycle counter enabled by BRAID_SCHED_PERF_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module braid_mix_scheduler
  import braid_sched_pkg::*;
#(
  parameter int  LANES      = DEF_LANES,
  parameter int  STAGES     = DEF_STAGES,
  parameter int  MIX_CYCLES = DEF_MIX_CYCLES,
  localparam int SW         = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int PW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LANES-1:0] load_req,
  output logic [LANES-1:0] load_gnt,
  output logic             mix_en,
  output logic             step,
  output logic [SW-1:0]    stage_idx,
  output logic             busy,
  output logic             done
`ifdef BRAID_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] run_cycles
`endif
);

  localparam logic [CNT_W-1:0] MIX_RELOAD = CNT_W'(MIX_CYCLES - 1);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(STAGES - 1);

  state_t           state;
  logic [LANES-1:0] loaded;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_next;
  logic [CNT_W-1:0] mix_cnt;
  logic [LANES-1:0] grant;

  braid_rr_arbiter #(.LANES(LANES)) u_arb (
    .req   (load_req),
    .mask  (loaded),
    .ptr   (ptr),
    .grant (grant)
  );

  // Pointer moves to the lane just after the one granted.
  always_comb begin
    ptr_next = ptr;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) ptr_next = (i == LANES - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      loaded    <= '0;
      ptr       <= '0;
      mix_cnt   <= '0;
      load_gnt  <= '0;
      mix_en    <= 1'b0;
      step      <= 1'b0;
      stage_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      load_gnt <= '0;
      step     <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        loaded    <= '0;
        mix_cnt   <= '0;
        mix_en    <= 1'b0;
        stage_idx <= '0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state     <= ST_LOAD;
              loaded    <= '0;
              stage_idx <= '0;
              busy      <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (&loaded) begin
              state   <= ST_MIX;
              mix_en  <= 1'b1;
              mix_cnt <= MIX_RELOAD;
            end else if (|grant) begin
              load_gnt <= grant;
              loaded   <= loaded | grant;
              ptr      <= ptr_next;
            end
          end
          ST_MIX: begin
            if (mix_cnt == '0) begin
              state  <= ST_ADVANCE;
              mix_en <= 1'b0;
              step   <= 1'b1;
            end else begin
              mix_cnt <= mix_cnt - 1'b1;
            end
          end
          ST_ADVANCE: begin
            if (stage_idx < LAST_STAGE) begin
              stage_idx <= stage_idx + 1'b1;
              state     <= ST_MIX;
              mix_en    <= 1'b1;
              mix_cnt   <= MIX_RELOAD;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            state     <= ST_IDLE;
            stage_idx <= '0;
            loaded    <= '0;
            busy      <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef BRAID_SCHED_PERF_EN
  // Counts every non-idle cycle of the latest run; frozen once back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cycles <= '0;
    end else if (state == ST_IDLE) begin
      if (start && !abort) run_cycles <= '0;
    end else if (run_cycles != '1) begin
      run_cycles <= run_cycles + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_braid_mix_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_braid_mix_scheduler                                                     |
// | Directed scenarios plus random traffic checked against a run-level model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_braid_mix_scheduler;

  localparam int LANES  = 4;
  localparam int STAGES = 32;
  localparam int MC     = 4;
  localparam int P      = MC + 1;
  localparam int TOTAL  = STAGES * P;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LANES-1:0] load_req = '0;
  logic [LANES-1:0] load_gnt;
  logic             mix_en, step, busy, done;
  logic [4:0]       stage_idx;
`ifdef BRAID_SCHED_PERF_EN
  logic [15:0]      run_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  braid_mix_scheduler #(.LANES(LANES), .STAGES(STAGES), .MIX_CYCLES(MC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .load_req  (load_req),
    .load_gnt  (load_gnt),
    .mix_en    (mix_en),
    .step      (step),
    .stage_idx (stage_idx),
    .busy      (busy),
    .done      (done)
`ifdef BRAID_SCHED_PERF_EN
    ,
    .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- run-level reference model ----------------
  // mode: 0 idle, 1 loading, 2 stage sequencing (position tracked as cycle offset)
  int               mode = 0;
  int               m_ptr = 0;
  int               off = 0;
  int               g;
  logic [LANES-1:0] m_loaded = '0;
  logic [LANES-1:0] e_gnt = '0;
  bit               e_mix = 0, e_step = 0, e_busy = 0, e_done = 0;
  int               e_stage = 0;
  int               e_runc = 0;

  function automatic int rr_pick(input logic [LANES-1:0] req, input logic [LANES-1:0] ld, input int p);
    int l;
    for (int i = 0; i < LANES; i++) begin
      l = (p + i) % LANES;
      if (req[l] && !ld[l]) return l;
    end
    return -1;
  endfunction

  // Each stage occupies MC mixing cycles followed by one step cycle; done follows the last.
  function automatic void run_outputs(input int o);
    if (o < TOTAL) begin
      e_stage = o / P;
      e_mix   = (o % P) < MC;
      e_step  = (o % P) == MC;
    end else begin
      e_stage = STAGES - 1;
      e_done  = 1'b1;
    end
    e_busy = 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = 0; m_ptr = 0; off = 0; m_loaded = '0; e_gnt = '0;
      e_mix = 0; e_step = 0; e_busy = 0; e_done = 0; e_stage = 0; e_runc = 0;
    end else begin
      if (mode != 0) e_runc = (e_runc < 65535) ? e_runc + 1 : e_runc;
      else if (start && !abort) e_runc = 0;
      e_gnt = '0; e_mix = 0; e_step = 0; e_done = 0;
      if (abort) begin
        mode = 0; m_loaded = '0; e_stage = 0; e_busy = 0;
      end else if (mode == 0) begin
        if (start) begin
          mode = 1; m_loaded = '0; e_stage = 0; e_busy = 1;
        end
      end else if (mode == 1) begin
        if (&m_loaded) begin
          mode = 2; off = 0; run_outputs(0);
        end else begin
          g = rr_pick(load_req, m_loaded, m_ptr);
          if (g >= 0) begin
            e_gnt[g] = 1'b1; m_loaded[g] = 1'b1; m_ptr = (g + 1) % LANES;
          end
        end
      end else begin
        off++;
        if (off > TOTAL) begin
          mode = 0; e_stage = 0; e_busy = 0;
        end else begin
          run_outputs(off);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("load_gnt", 32'(load_gnt), 32'(e_gnt));
      chk("mix_en", 32'(mix_en), 32'(e_mix));
      chk("step", 32'(step), 32'(e_step));
      chk("stage_idx", 32'(stage_idx), 32'(e_stage));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
`ifdef BRAID_SCHED_PERF_EN
      chk("run_cycles", 32'(run_cycles), 32'(e_runc));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_idle(output int nmix, output int nstep, output int ndone, output int bad_stage);
    nmix = 0; nstep = 0; ndone = 0; bad_stage = 0;
    for (int n = 0; n < 1000 && busy; n++) begin
      if (mix_en) nmix++;
      if (step) begin
        if (32'(stage_idx) != nstep) bad_stage++;
        nstep++;
      end
      if (done) ndone++;
      tick();
    end
    chk("run_timeout_busy", 32'(busy), 32'd0);
  endtask

  int          nmix, nstep, ndone, bad_stage;
  logic [3:0]  expg;

  initial begin
    #2 rst_n = 1'b0;
    check_en = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(load_gnt), 32'd0);
    chk("rst_stage", 32'(stage_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // All lanes ready: grants walk 0..3, then a full 32-stage run.
    load_req = 4'b1111;
    pulse_start();
    expg = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_gnt", 32'(load_gnt), 32'(expg));
      expg = expg << 1;
    end
    tick();
    chk("s1_mix_enter", 32'(mix_en), 32'd1);
    chk("s1_gnt_after", 32'(load_gnt), 32'd0);
    run_to_idle(nmix, nstep, ndone, bad_stage);
    chk("s2_mix_cycles", 32'(nmix), 32'd128);
    chk("s2_steps", 32'(nstep), 32'd32);
    chk("s2_done", 32'(ndone), 32'd1);
    chk("s2_stage_seq", 32'(bad_stage), 32'd0);

    // Partial readiness stalls LOAD until the rest arrive.
    load_req = 4'b0101;
    pulse_start();
    tick(); chk("s4_gnt0", 32'(load_gnt), 32'b0001);
    tick(); chk("s4_gnt1", 32'(load_gnt), 32'b0100);
    repeat (3) begin
      tick();
      chk("s4_hold_gnt", 32'(load_gnt), 32'd0);
      chk("s4_hold_mix", 32'(mix_en), 32'd0);
      chk("s4_hold_busy", 32'(busy), 32'd1);
    end
    load_req = 4'b0111;
    tick(); chk("s4_gnt2", 32'(load_gnt), 32'b0010);
    load_req = 4'b1111;
    tick(); chk("s4_gnt3", 32'(load_gnt), 32'b1000);
    tick(); chk("s4_mix_enter", 32'(mix_en), 32'd1);

    // Abort mid-run at stage 7.
    for (int n = 0; n < 200; n++) begin
      if (stage_idx == 5'd7 && mix_en) break;
      tick();
    end
    chk("s5_reach7", 32'(stage_idx), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_mix", 32'(mix_en), 32'd0);
    chk("s5_stage", 32'(stage_idx), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    repeat (4) begin
      tick();
      chk("s5_no_done", 32'(done), 32'd0);
    end

    // Run ending on lane 1, then pointer carries into the next run.
    load_req = 4'b1101;
    pulse_start();
    tick(); chk("s3_gnt0", 32'(load_gnt), 32'b0001);
    tick(); chk("s3_gnt1", 32'(load_gnt), 32'b0100);
    tick(); chk("s3_gnt2", 32'(load_gnt), 32'b1000);
    load_req = 4'b1111;
    tick(); chk("s3_gnt3", 32'(load_gnt), 32'b0010);
    tick();
    run_to_idle(nmix, nstep, ndone, bad_stage);
    chk("s3_steps", 32'(nstep), 32'd32);
    chk("s3_done", 32'(ndone), 32'd1);
    pulse_start();
    tick(); chk("s3_ptr_persist", 32'(load_gnt), 32'b0100);

    // Reset in the middle of LOAD.
    #1 rst_n = 1'b0;
    #1;
    chk("s6_gnt", 32'(load_gnt), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_mix", 32'(mix_en), 32'd0);
    chk("s6_step", 32'(step), 32'd0);
    chk("s6_stage", 32'(stage_idx), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
`ifdef BRAID_SCHED_PERF_EN
    chk("s6_run_cycles", 32'(run_cycles), 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      start    = ($urandom % 6) == 0;
      abort    = ($urandom % 250) == 0;
      load_req = 4'($urandom);
      if (($urandom % 1500) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
